ddr4_app_arbiter: RTL and testbench
===================================

Name: ddr4_app_arbiter

Overview:
- Shares the DDR4 MIG user (app_*) interface of ddr4_brc_wrapper between NUM_REQ requesters using round-robin arbitration.
- Each requester issues single-beat commands; a write carries its full 640-bit burst with the command.
- Issues one command at a time to the MIG, honouring app_rdy and app_wdf_rdy.
- Routes in-order read returns to the originating requester through a requester-ID tag FIFO.
- Sits in the c0_ddr4_ui_clk domain, between the DMA/host engines and the MIG wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 28, app address width.
- DATA_W, 640, app data width (one BL8 burst).
- MASK_W, 80, byte-mask width (DATA_W/8).
- RD_TAG_DEPTH, 32, maximum outstanding reads; power of two.

Ports:
- c0_ddr4_ui_clk  in  1  clock, MIG UI clock.
- rst  in  1  asynchronous, active-high reset.
- c0_init_calib_complete  in  1  no grants are issued while this is 0.
- req_cmd_valid  in  NUM_REQ  per-requester command valid.
- req_cmd_ready  out  NUM_REQ  one-hot grant pulse; the command is accepted on valid&ready.
- req_cmd_write  in  NUM_REQ  1 = write, 0 = read.
- req_cmd_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_wmask  in  NUM_REQ*MASK_W  packed masks; 1 = byte not written.
- rsp_rdata  out  DATA_W  read data, broadcast to all requesters.
- rsp_valid  out  NUM_REQ  one-hot; marks rsp_rdata as belonging to requester i.
- app_addr  out  ADDR_W  to MIG.
- app_cmd  out  3  to MIG; 3'b000 = write, 3'b001 = read.
- app_en  out  1  to MIG.
- app_hi_pri  out  1  tied to 0.
- app_wdf_data  out  DATA_W  to MIG.
- app_wdf_mask  out  MASK_W  to MIG.
- app_wdf_wren  out  1  to MIG.
- app_wdf_end  out  1  to MIG.
- app_rdy  in  1  from MIG.
- app_wdf_rdy  in  1  from MIG.
- app_rd_data  in  DATA_W  from MIG.
- app_rd_data_valid  in  1  from MIG.
- app_rd_data_end  in  1  from MIG; ignored.
- rd_tag_full  out  1  status; tag FIFO holds RD_TAG_DEPTH entries.
- err_orphan_rd  out  1  sticky; app_rd_data_valid arrived while the tag FIFO was empty.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, RR pointer selects requester 0 first, tag FIFO is empty, err_orphan_rd is cleared.
  - Reset applies asynchronously at any time, including mid-issue.
  - Outstanding read tags are discarded on reset.
- Eligibility: requester i is eligible when all of the following hold:
  - req_cmd_valid[i] = 1;
  - c0_init_calib_complete = 1;
  - req_cmd_write[i] = 1, or tag count + reserved < RD_TAG_DEPTH;
  - the FSM can accept, i.e. it is IDLE, or it is ISSUE and completes this cycle.
- Arbitration:
  - Round-robin, starting from (last_grant+1) mod NUM_REQ.
  - Grant is combinational: req_cmd_ready[g] = 1 for one cycle.
  - The pointer updates to g on grant.
- Grant cycle T actions:
  - Register addr, cmd, data and mask into the app_* output registers.
  - Set app_en = 1 at T+1.
  - For a write, also set app_wdf_wren = app_wdf_end = 1 at T+1.
  - For a read, push ID g into the tag FIFO at T.
- FSM states:
  - IDLE: go to ISSUE on grant.
  - ISSUE:
    - app_en is held until the cycle where app_rdy = 1, then drops unless a new grant occurs in that same cycle.
    - app_wdf_wren/app_wdf_end are held until app_wdf_rdy = 1, independently of app_en; data and command may complete in different cycles.
    - ISSUE is complete when both the command and data handshakes (data only for writes) are done, including completion in the current cycle.
    - On completion: go to IDLE, or stay in ISSUE if a new grant is issued in the completing cycle.
  - Throughput: back-to-back commands issue at one per cycle while app_rdy = app_wdf_rdy = 1.
- Read return:
  - On app_rd_data_valid, pop the FIFO head h.
  - At the next cycle: rsp_valid[h] = 1 and rsp_rdata = app_rd_data (registered, latency 1).
  - If the FIFO is empty: drop the data, set err_orphan_rd, and leave rsp_valid at 0.
- Tag FIFO:
  - Count is 0..RD_TAG_DEPTH.
  - A simultaneous push and pop leaves the count unchanged; the pop happens first when count = RD_TAG_DEPTH.
  - Pointers wrap modulo RD_TAG_DEPTH.
  - rd_tag_full = (count == RD_TAG_DEPTH).
  - Full blocks read grants only; writes still proceed.
- Calibration: if c0_init_calib_complete falls mid-ISSUE, the current command completes and no new grants are made.

Decomposition:
- Shared package ddr4_arb_pkg holds:
  - APP_CMD_WR = 3'b000 and APP_CMD_RD = 3'b001;
  - width constants ADDR_W, DATA_W, MASK_W;
  - the FSM state enum (IDLE, ISSUE).
- One sub-module, ddr4_arb_tag_fifo:
  - register-based, depth RD_TAG_DEPTH, width clog2(NUM_REQ);
  - provides push, pop, head, count and full.

Test Plan:
- Reset release, calib = 0, both requesters valid -> no req_cmd_ready ever asserts; all app_* outputs stay 0. Raising calib grants req0 first.
- Both requesters stream writes, app_rdy = app_wdf_rdy = 1 -> grants alternate 0,1,0,1; app_en is high every cycle; app_addr/app_wdf_data match the granted requester.
- Write with app_rdy stalled 3 cycles while app_wdf_rdy = 1 -> wdf_wren drops after 1 cycle, app_en is held 3 more cycles, and no new grant is made until app_rdy.
- req0 read A, req1 read B, req0 read C, MIG returns D0, D1, D2 -> rsp_valid = 01, 10, 01 with rsp_rdata = D0, D1, D2, each 1 cycle after the corresponding valid.
- Issue 32 reads with no returns -> rd_tag_full = 1, the 33rd read is blocked while a pending write is still granted. One return followed by a read in the same cycle -> grant proceeds, count stays 32.
- Assert rst mid-ISSUE with 5 reads outstanding, then the MIG returns data -> all outputs go to 0 immediately; after release, err_orphan_rd = 1 and no rsp_valid pulses.

Source files
------------

// File: rtl/ddr4_arb_pkg.sv
// Shared constants and types for the DDR4 MIG app-interface arbiter.
package ddr4_arb_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 640;
    localparam int MASK_W = 80;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ddr4_arb_tag_fifo.sv
// Register-based FIFO of requester IDs for in-flight reads. MIG read data
// returns in issue order, so the head always names the owner of the next beat.
module ddr4_arb_tag_fifo #(
    parameter int  DEPTH = 32,
    parameter int  ID_W  = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [ID_W-1:0]  i_push_id,
    input  logic             i_pop,
    output logic [ID_W-1:0]  o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [ID_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify push/pop: a pop frees its slot first, so a push into a full FIFO
    // is only legal when a pop happens in the same cycle.
    always_comb begin
        w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});
        w_do_push = i_push && ((r_count != FULL_C) || w_do_pop);
    end

    // Storage array; written at the write pointer on every accepted push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ID_W{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_C);

endmodule

// File: rtl/ddr4_app_arbiter.sv
// Round-robin sharing of the DDR4 MIG app_* interface between NUM_REQ
// requesters. One command is in flight towards the MIG at a time; read data
// is steered back to its requester through an in-order tag FIFO.
module ddr4_app_arbiter
    import ddr4_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = ddr4_arb_pkg::ADDR_W,
    parameter int DATA_W       = ddr4_arb_pkg::DATA_W,
    parameter int MASK_W       = ddr4_arb_pkg::MASK_W,
    parameter int RD_TAG_DEPTH = 32
) (
    input  logic                      c0_ddr4_ui_clk,
    input  logic                      rst,
    input  logic                      c0_init_calib_complete,
    input  logic [NUM_REQ-1:0]        req_cmd_valid,
    output logic [NUM_REQ-1:0]        req_cmd_ready,
    input  logic [NUM_REQ-1:0]        req_cmd_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_cmd_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*MASK_W-1:0] req_wmask,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [ADDR_W-1:0]         app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    output logic                      app_hi_pri,
    output logic [DATA_W-1:0]         app_wdf_data,
    output logic [MASK_W-1:0]         app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    input  logic [DATA_W-1:0]         app_rd_data,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end,
    output logic                      rd_tag_full,
    output logic                      err_orphan_rd
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RD_TAG_DEPTH + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [ID_W-1:0]     r_last;
    logic [ADDR_W-1:0]   r_app_addr;
    logic [2:0]          r_app_cmd;
    logic                r_app_en;
    logic [DATA_W-1:0]   r_wdf_data;
    logic [MASK_W-1:0]   r_wdf_mask;
    logic                r_wdf_wren;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_err_orphan;

    logic                w_complete;
    logic                w_can_accept;
    logic                w_tag_room;
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_grant_any;
    logic [ID_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]  w_grant_oh;
    logic                w_grant_wr;
    logic                w_tag_push;
    logic [ID_W-1:0]     w_tag_head;
    logic [CNT_W-1:0]    w_tag_count;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic [NUM_REQ-1:0]  w_head_oh;
    logic                w_unused_rd_end;

    // The end-of-burst strobe carries no information for single-beat reads.
    assign w_unused_rd_end = app_rd_data_end;

    // Issue completes once the command and (for writes) the data handshakes
    // are done; both may finish in this very cycle. A full tag FIFO still has
    // room for a read if a return pops a tag in the same cycle.
    always_comb begin
        w_complete   = (r_state == ST_ISSUE)
                     && (!r_app_en   || app_rdy)
                     && (!r_wdf_wren || app_wdf_rdy);
        w_can_accept = (r_state == ST_IDLE) || w_complete;
        w_tag_room   = (w_tag_count < CNT_W'(RD_TAG_DEPTH)) || app_rd_data_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_cmd_valid[i] && c0_init_calib_complete && w_can_accept
                      && (req_cmd_write[i] || w_tag_room) && !rst;
        end
    end

    // Round-robin pick starting one past the last granted requester.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = {ID_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_grant_any && w_elig[(int'(r_last) + k) % NUM_REQ]) begin
                w_grant_any = 1'b1;
                w_grant_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            end else begin
                w_grant_any = w_grant_any;
            end
        end
    end

    // One-hot views of the granted requester and of the tag FIFO head.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_oh[i] = w_grant_any && (w_grant_idx == ID_W'(i));
            w_head_oh[i]  = (w_tag_head == ID_W'(i));
        end
        w_grant_wr  = req_cmd_write[w_grant_idx];
        w_tag_push  = w_grant_any && !w_grant_wr;
        w_tag_empty = (w_tag_count == {CNT_W{1'b0}});
    end

    // FSM state register.
    always_ff @(posedge c0_ddr4_ui_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a grant in the completing cycle keeps us in ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_complete && !w_grant_any) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin pointer follows the most recent grant.
    always_ff @(posedge c0_ddr4_ui_clk or posedge rst) begin
        if (rst) begin
            r_last <= ID_W'(NUM_REQ - 1);
        end else if (w_grant_any) begin
            r_last <= w_grant_idx;
        end
    end

    // MIG command/data registers: loaded on grant, strobes held until their
    // own handshake so command and data may complete in different cycles.
    always_ff @(posedge c0_ddr4_ui_clk or posedge rst) begin
        if (rst) begin
            r_app_addr <= {ADDR_W{1'b0}};
            r_app_cmd  <= 3'b000;
            r_app_en   <= 1'b0;
            r_wdf_data <= {DATA_W{1'b0}};
            r_wdf_mask <= {MASK_W{1'b0}};
            r_wdf_wren <= 1'b0;
        end else if (w_grant_any) begin
            r_app_addr <= req_cmd_addr[int'(w_grant_idx) * ADDR_W +: ADDR_W];
            r_app_cmd  <= w_grant_wr ? APP_CMD_WR : APP_CMD_RD;
            r_app_en   <= 1'b1;
            r_wdf_data <= req_wdata[int'(w_grant_idx) * DATA_W +: DATA_W];
            r_wdf_mask <= req_wmask[int'(w_grant_idx) * MASK_W +: MASK_W];
            r_wdf_wren <= w_grant_wr;
        end else begin
            r_app_en   <= r_app_en && !app_rdy;
            r_wdf_wren <= r_wdf_wren && !app_wdf_rdy;
        end
    end

    // Read return: steer data to the head tag's owner one cycle later; data
    // with no outstanding tag is dropped and flagged.
    always_ff @(posedge c0_ddr4_ui_clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid  <= {NUM_REQ{1'b0}};
            r_rsp_rdata  <= {DATA_W{1'b0}};
            r_err_orphan <= 1'b0;
        end else if (app_rd_data_valid) begin
            if (!w_tag_empty) begin
                r_rsp_valid <= w_head_oh;
                r_rsp_rdata <= app_rd_data;
            end else begin
                r_rsp_valid  <= {NUM_REQ{1'b0}};
                r_err_orphan <= 1'b1;
            end
        end else begin
            r_rsp_valid <= {NUM_REQ{1'b0}};
        end
    end

    ddr4_arb_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH),
        .ID_W  (ID_W)
    ) u_tag_fifo (
        .i_clk     (c0_ddr4_ui_clk),
        .i_rst     (rst),
        .i_push    (w_tag_push),
        .i_push_id (w_grant_idx),
        .i_pop     (app_rd_data_valid),
        .o_head    (w_tag_head),
        .o_count   (w_tag_count),
        .o_full    (w_tag_full)
    );

    assign req_cmd_ready = w_grant_oh;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_valid     = r_rsp_valid;
    assign app_addr      = r_app_addr;
    assign app_cmd       = r_app_cmd;
    assign app_en        = r_app_en;
    assign app_hi_pri    = 1'b0;
    assign app_wdf_data  = r_wdf_data;
    assign app_wdf_mask  = r_wdf_mask;
    assign app_wdf_wren  = r_wdf_wren;
    assign app_wdf_end   = r_wdf_wren;
    assign rd_tag_full   = w_tag_full;
    assign err_orphan_rd = r_err_orphan;

endmodule

// File: tb/tb_ddr4_app_arbiter.sv
// Scoreboard bench for ddr4_app_arbiter: randomized requester/MIG traffic,
// transaction-level reference model, decoupled output monitor.
module tb_ddr4_app_arbiter;

    localparam int NR = 2;
    localparam int AW = 28;
    localparam int DW = 640;
    localparam int MW = 80;
    localparam int TD = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             calib;
    logic [NR-1:0]    req_valid, req_ready, req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*MW-1:0] req_wmask;
    logic [DW-1:0]    rsp_rdata;
    logic [NR-1:0]    rsp_valid;
    logic [AW-1:0]    app_addr;
    logic [2:0]       app_cmd;
    logic             app_en, app_hi_pri, app_wdf_wren, app_wdf_end;
    logic [DW-1:0]    app_wdf_data;
    logic [MW-1:0]    app_wdf_mask;
    logic             app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic [DW-1:0]    app_rd_data;
    logic             rd_tag_full, err_orphan_rd;

    ddr4_app_arbiter dut (
        .c0_ddr4_ui_clk(clk), .rst(rst), .c0_init_calib_complete(calib),
        .req_cmd_valid(req_valid), .req_cmd_ready(req_ready), .req_cmd_write(req_write),
        .req_cmd_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_hi_pri(app_hi_pri),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .rd_tag_full(rd_tag_full), .err_orphan_rd(err_orphan_rd)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [2:0] cmd; longint due; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; longint due; } wd_t;
    typedef struct { int id; logic [DW-1:0] data; longint due; } rsp_t;

    cmd_t   cmd_q[$];
    wd_t    wd_q[$];
    rsp_t   rsp_q[$];
    int     tags[$];
    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    logic   mon_en = 1'b0;
    logic   m_cmd_owed, m_data_owed, m_err;
    int     m_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [MW-1:0] rand_mw();
        logic [95:0] t;
        for (int i = 0; i < 3; i++) t[i*32 +: 32] = $urandom();
        return t[MW-1:0];
    endfunction

    task automatic drive(input logic c, input logic [NR-1:0] v, input logic [NR-1:0] w,
                         input logic ar, input logic wr, input logic rdv);
        calib = c; req_valid = v; req_write = w;
        app_rdy = ar; app_wdf_rdy = wr;
        app_rd_data_valid = rdv; app_rd_data_end = rdv;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = AW'($urandom());
            req_wdata[i*DW +: DW] = rand_dw();
            req_wmask[i*MW +: MW] = rand_mw();
        end
        app_rd_data = rand_dw();
    endtask

    task automatic model_reset();
        cmd_q.delete(); wd_q.delete(); rsp_q.delete(); tags.delete();
        m_cmd_owed = 1'b0; m_data_owed = 1'b0; m_err = 1'b0; m_last = NR - 1;
    endtask

    // Reference model evaluated mid-cycle with inputs stable: predicts the
    // grant, then records what the MIG side and the requesters should see.
    task automatic model_cycle();
        logic          busy, room;
        logic [NR-1:0] elig, exp_rdy;
        int            g, j, h;
        chk("rd_tag_full", rd_tag_full, tags.size() == TD);
        chk("err_orphan_rd", err_orphan_rd, m_err);
        busy = (m_cmd_owed && !app_rdy) || (m_data_owed && !app_wdf_rdy);
        room = (tags.size() < TD) || app_rd_data_valid;
        for (int i = 0; i < NR; i++)
            elig[i] = req_valid[i] && calib && !busy && (req_write[i] || room);
        g = -1;
        for (int k = 1; k <= NR; k++) begin
            j = (m_last + k) % NR;
            if (g < 0 && elig[j]) g = j;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_cmd_ready", req_ready, exp_rdy);
        if (app_rd_data_valid) begin
            if (tags.size() > 0) begin
                h = tags.pop_front();
                rsp_q.push_back('{h, app_rd_data, cyc + 1});
            end else begin
                m_err = 1'b1;
            end
        end
        if (g >= 0) begin
            cmd_q.push_back('{req_addr[g*AW +: AW], req_write[g] ? 3'b000 : 3'b001, cyc + 1});
            if (req_write[g]) wd_q.push_back('{req_wdata[g*DW +: DW], req_wmask[g*MW +: MW], cyc + 1});
            else tags.push_back(g);
            m_cmd_owed  = 1'b1;
            m_data_owed = req_write[g];
            m_last      = g;
        end else begin
            m_cmd_owed  = m_cmd_owed && !app_rdy;
            m_data_owed = m_data_owed && !app_wdf_rdy;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every MIG-side and response-side output against the queues.
    always @(negedge clk) begin : monitor
        logic exp_en, exp_wr, exp_rv;
        logic [NR-1:0] exp_oh;
        if (mon_en && !rst) begin
            exp_en = (cmd_q.size() > 0) && (cmd_q[0].due <= cyc);
            chk("app_en", app_en, exp_en);
            chk("app_hi_pri", app_hi_pri, 1'b0);
            if (exp_en && app_rdy) begin
                chk("app_addr", app_addr, cmd_q[0].addr);
                chk("app_cmd", app_cmd, cmd_q[0].cmd);
                void'(cmd_q.pop_front());
            end
            exp_wr = (wd_q.size() > 0) && (wd_q[0].due <= cyc);
            chk("app_wdf_wren", app_wdf_wren, exp_wr);
            chk("app_wdf_end", app_wdf_end, exp_wr);
            if (exp_wr && app_wdf_rdy) begin
                chk("app_wdf_data", app_wdf_data, wd_q[0].data);
                chk("app_wdf_mask", app_wdf_mask, wd_q[0].mask);
                void'(wd_q.pop_front());
            end
            exp_rv = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
            exp_oh = '0;
            if (exp_rv) exp_oh[rsp_q[0].id] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_oh);
            if (exp_rv) begin
                chk("rsp_rdata", rsp_rdata, rsp_q[0].data);
                void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Calibration low: nothing may be granted, outputs stay idle.
        for (int n = 0; n < 10; n++) begin drive(1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0); step(); end
        chk("app_addr_idle", app_addr, '0);
        chk("app_wdf_data_idle", app_wdf_data, '0);

        // Streaming writes from both requesters, MIG always ready.
        for (int n = 0; n < 8; n++) begin drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0); step(); end

        // Command stall with data ready.
        for (int n = 0; n < 4; n++) begin drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0); step(); end
        for (int n = 0; n < 2; n++) begin drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0); step(); end

        // Random mix of reads, writes, stalls, returns and calibration drops.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 99) < 95, NR'($urandom()), NR'($urandom()),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                  (tags.size() > 0) && ($urandom_range(0, 99) < 35));
            step();
        end
        for (int n = 0; n < 3; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b0); step(); end
        for (int n = 0; n < 64 && tags.size() > 0; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1); step(); end

        // Fill the tag FIFO: req0 reads until full, req1 writes keep flowing.
        for (int n = 0; n < 80; n++) begin drive(1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0); step(); end
        chk("full_after_fill", rd_tag_full, 1'b1);
        drive(1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1); step();
        drive(1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0); step();
        chk("full_after_pop_push", rd_tag_full, 1'b1);
        for (int n = 0; n < 64 && tags.size() > 0; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1); step(); end
        for (int n = 0; n < 3; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b0); step(); end
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);

        // Reset mid-issue with reads outstanding.
        for (int n = 0; n < 40 && tags.size() < 5; n++) begin drive(1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0); step(); end
        for (int n = 0; n < 2; n++) begin drive(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0); step(); end
        rst = 1'b1;
        #1;
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_app_addr", app_addr, '0);
        chk("rst_app_cmd", app_cmd, '0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_tag_full", rd_tag_full, 1'b0);
        chk("rst_err", err_orphan_rd, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b1); step(); end
        for (int n = 0; n < 3; n++) begin drive(1'b1, '0, '0, 1'b1, 1'b1, 1'b0); step(); end
        chk("orphan_sticky", err_orphan_rd, 1'b1);
        chk("rsp_q_end", rsp_q.size(), 0);
        chk("wd_q_end", wd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
